// File: rtl/icache_refill_responder_pkg.sv
// Shared cache memory-interface types, line geometry constants and the
// refill FSM state encoding.
package cache_def;

  localparam int unsigned LINE_W        = 128;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned LINE_BYTES    = 16;
  localparam int unsigned WORD_OFFSET_W = 2;
  localparam int unsigned BYTE_OFFSET_W = 2;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RESPOND,
    ST_HOLDOFF
  } refill_state_e;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/icache_refill_responder_timeout.sv
// Per-transaction watchdog: counts enabled cycles, restarts on clear and
// flags expiry in the cycle that would reach the limit.
module refill_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is flagged during the TIMEOUT-th enabled cycle so the owner can
  // abort on that same edge.
  assign expired = en && !clr && (count == LIMIT);

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side responder: turns one cache line-fill or write-back request into
// ascending 32-bit word-bus transactions and returns the assembled line.
module icache_refill_responder
  import cache_def::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  mem_req_type  mem_req_i,
  output mem_data_type mem_data_o,
  output logic         bus_req_o,
  output logic         bus_we_o,
  output logic [31:0]  bus_addr_o,
  output logic [31:0]  bus_wdata_o,
  input  logic         bus_gnt_i,
  input  logic         bus_rvalid_i,
  input  logic [31:0]  bus_rdata_i,
  output logic         err_o,
  output logic         busy_o
);

  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_words_t;

  localparam logic [WORD_OFFSET_W-1:0] LAST_WC = WORD_OFFSET_W'(WORDS_PER_LINE - 1);

  refill_state_e              state_q, state_d;
  logic [WORD_OFFSET_W-1:0]   wc_q, wc_d;
  logic [31:0]                line_addr_q, line_addr_d;
  logic                       rw_q, rw_d;
  line_words_t                wdata_q, wdata_d;
  line_words_t                buf_q, buf_d;
  logic [LINE_W-1:0]          data_q, data_d;
  logic                       err_q, err_d;
  logic                       word_done;
  logic                       tmo_en, tmo_clr, tmo_expired;

  assign tmo_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP);
  assign tmo_clr = bus_gnt_i || bus_rvalid_i;

  refill_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wc_q        <= '0;
      line_addr_q <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      line_addr_q <= line_addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    line_addr_d = line_addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    data_d      = data_q;
    err_d       = err_q;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    word_done   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_i.valid) begin
          line_addr_d = line_base(mem_req_i.addr);
          rw_d        = mem_req_i.rw;
          wdata_d     = mem_req_i.data;
          wc_d        = '0;
          buf_d       = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus_req_o   = 1'b1;
        bus_we_o    = rw_q;
        bus_addr_o  = line_addr_q + 32'({wc_q, {BYTE_OFFSET_W{1'b0}}});
        bus_wdata_o = wdata_q[wc_q];
        // A same-cycle rvalid completes the word without a WAIT_RSP dwell.
        if (bus_gnt_i) begin
          state_d   = ST_WAIT_RSP;
          word_done = bus_rvalid_i;
        end
      end
      ST_WAIT_RSP: word_done = bus_rvalid_i;
      ST_RESPOND:  state_d   = ST_HOLDOFF;
      ST_HOLDOFF:  state_d   = ST_IDLE;
      default:     state_d   = ST_IDLE;
    endcase

    // Word completion and watchdog abort are shared by ISSUE and WAIT_RSP.
    if (word_done) begin
      if (!rw_q) buf_d[wc_q] = bus_rdata_i;
      if (wc_q == LAST_WC) begin
        state_d = ST_RESPOND;
        data_d  = rw_q ? '0 : buf_d;
      end else begin
        wc_d    = wc_q + 1'b1;
        state_d = ST_ISSUE;
      end
    end else if (tmo_expired) begin
      err_d   = 1'b1;
      data_d  = '0;
      state_d = ST_RESPOND;
    end
  end

  assign mem_data_o.data  = data_q;
  assign mem_data_o.ready = (state_q == ST_RESPOND);
  assign err_o            = err_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icache_refill_responder.sv
// Scoreboard bench: expected bus words and line responses are queued when a
// request is launched and checked as the DUT produces them.
module tb_icache_refill_responder;
  import cache_def::*;

  localparam int unsigned TMO = 8;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_op_t;

  typedef struct {
    logic [127:0] data;
    int unsigned  cyc;
    logic         err;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst;
  mem_req_type  req;
  mem_data_type rsp;
  logic         bus_req, bus_we, bus_gnt, bus_rvalid, err, busy;
  logic [31:0]  bus_addr, bus_wdata, bus_rdata;

  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;
  int unsigned  cyc = 0;
  int unsigned  gnt_dly = 0;
  int unsigned  rsp_dly = 0;
  bit           no_grant = 1'b0;
  bit           force_rvalid = 1'b0;
  bit           err_sticky = 1'b0;

  bus_op_t      bus_q[$];
  resp_t        resp_q[$];

  icache_refill_responder #(
    .WORDS_PER_LINE(4),
    .TIMEOUT       (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_req_i   (req),
    .mem_data_o  (rsp),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_gnt_i   (bus_gnt),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i (bus_rdata),
    .err_o       (err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    case (a)
      32'h0000_1230: return 32'h1111_1111;
      32'h0000_1234: return 32'h2222_2222;
      32'h0000_1238: return 32'h3333_3333;
      32'h0000_123C: return 32'h4444_4444;
      default:       return a ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  // Word-bus slave: programmable grant / response delays, checks each request
  // against the queue and that it is held stable until granted.
  initial begin : slave
    bit          active, pend;
    int unsigned wait_n, rcnt;
    bus_op_t     op, exp_op;
    active = 1'b0; pend = 1'b0; wait_n = 0; rcnt = 0;
    op = '{addr: '0, we: 1'b0, wdata: '0};
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      if (busy === 1'b0) begin
        active = 1'b0; pend = 1'b0; wait_n = 0;
        if (force_rvalid) begin
          bus_rvalid = 1'b1;
          bus_rdata  = 32'hBAD0_BAD0;
        end
      end else if (pend) begin
        if (rcnt == rsp_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd_word(op.addr);
          pend = 1'b0;
        end else begin
          rcnt++;
        end
      end else if (bus_req === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          wait_n = 0;
          op = '{addr: bus_addr, we: bus_we, wdata: bus_wdata};
          check_eq("req_expected", bus_q.size() != 0, 1'b1);
          if (bus_q.size() != 0) begin
            exp_op = bus_q.pop_front();
            check_eq("bus_addr", bus_addr, exp_op.addr);
            check_eq("bus_we", bus_we, exp_op.we);
            if (exp_op.we) check_eq("bus_wdata", bus_wdata, exp_op.wdata);
          end
        end else begin
          check_eq("hold_addr", bus_addr, op.addr);
          check_eq("hold_we", bus_we, op.we);
          check_eq("hold_wdata", bus_wdata, op.wdata);
        end
        if (!no_grant && wait_n == gnt_dly) begin
          bus_gnt = 1'b1;
          active  = 1'b0;
          if (rsp_dly == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd_word(op.addr);
          end else begin
            pend = 1'b1;
            rcnt = 1;
          end
        end else begin
          wait_n++;
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rsp.ready === 1'b1) begin
        check_eq("rdy_expected", resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          check_eq("line_data", rsp.data, e.data);
          check_eq("rdy_cycle", cyc, e.cyc);
          check_eq("err_at_rdy", err, e.err);
        end
      end
    end
  end

  task automatic run_req(input logic [31:0] addr, input logic [127:0] data, input logic rw,
                         input int unsigned g, input int unsigned r, input bit hold, input bit tmo);
    logic [31:0]  base;
    logic [127:0] line;
    resp_t        e;
    int unsigned  c0, rdy_c, nw;
    bit           seen, done;
    base = addr & 32'hFFFF_FFF0;
    line = '0;
    gnt_dly = g; rsp_dly = r; no_grant = tmo;
    nw = tmo ? 1 : 4;
    for (int unsigned w = 0; w < nw; w++)
      bus_q.push_back('{addr: base + 4 * w, we: rw, wdata: data[32*w +: 32]});
    for (int unsigned w = 0; w < 4; w++)
      if (!rw && !tmo) line[32*w +: 32] = rd_word(base + 4 * w);
    @(negedge clk);
    c0 = cyc;
    e.data = line;
    e.cyc  = tmo ? c0 + 1 + TMO : c0 + 1 + 4 * (g + r + 1);
    e.err  = tmo ? 1'b1 : err_sticky;
    resp_q.push_back(e);
    req = '{addr: addr, data: data, rw: rw, valid: 1'b1};
    seen = 1'b0; done = 1'b0; rdy_c = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!hold && cyc == c0 + 1) req.valid = 1'b0;
      if (rsp.ready === 1'b1) begin seen = 1'b1; rdy_c = cyc; end
      if (hold && seen && cyc == rdy_c + 2) req.valid = 1'b0;
      if (seen && busy === 1'b0 && !req.valid) done = 1'b1;
    end
    req.valid = 1'b0;
    if (!done) check_eq("done_within_bound", done, 1'b1);
    else check_eq("busy_low_cycle", cyc, rdy_c + 2);
    if (tmo) err_sticky = 1'b1;
    check_eq("resp_drained", resp_q.size(), 0);
    check_eq("bus_drained", bus_q.size(), 0);
    check_eq("data_held", rsp.data, e.data);
    check_eq("err_level", err, err_sticky);
    @(negedge clk);
    check_eq("no_retrigger", busy, 1'b0);
    no_grant = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_bus_req"}, bus_req, 1'b0);
    check_eq({tag, "_bus_we"}, bus_we, 1'b0);
    check_eq({tag, "_bus_addr"}, bus_addr, 32'h0);
    check_eq({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    check_eq({tag, "_ready"}, rsp.ready, 1'b0);
    check_eq({tag, "_data"}, rsp.data, 128'h0);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic reset_mid_refill;
    logic [31:0] base;
    bit          found;
    base = 32'h0000_4000;
    gnt_dly = 0; rsp_dly = 3;
    for (int unsigned w = 0; w < 3; w++)
      bus_q.push_back('{addr: base + 4 * w, we: 1'b0, wdata: 32'h0});
    @(negedge clk);
    req = '{addr: base, data: 128'h0, rw: 1'b0, valid: 1'b1};
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      req.valid = 1'b0;
      if (bus_req === 1'b1 && bus_addr == base + 8) found = 1'b1;
    end
    check_eq("reached_word2", found, 1'b1);
    @(negedge clk);
    check_eq("word2_wait_no_req", bus_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    err_sticky = 1'b0;
    force_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    force_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("stale_rvalid_busy", busy, 1'b0);
    check_eq("stale_bus_drained", bus_q.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_time_limit: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    req = '{addr: '0, data: '0, rw: 1'b0, valid: 1'b0};
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_req(32'h0000_1234, 128'h0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_req(32'h8000_0010, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, 1, 1, 1'b0, 1'b0);
    run_req(32'h0000_2008, 128'h0, 1'b0, 3, 2, 1'b0, 1'b0);
    run_req(32'h0000_3010, 128'h0, 1'b0, 0, 1, 1'b1, 1'b0);
    run_req(32'h0000_3024, 128'h0, 1'b0, 2, 0, 1'b0, 1'b0);
    run_req(32'h0000_5000, 128'h0, 1'b0, 0, 0, 1'b0, 1'b1);
    run_req(32'h0000_6000, 128'h0, 1'b0, 0, 0, 1'b0, 1'b0);
    reset_mid_refill();
    run_req(32'h0000_7030, 128'h0, 1'b0, 1, 2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
